// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cla_pkg;

  // Width of one lookahead group; the adder is built from WIDTH/GROUP_W groups.
  localparam int GROUP_W = 4;

  // Operation select carried on the 'sub' input.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Group-level generate/propagate pair.
  typedef struct packed {
    logic g;
    logic p;
  } grp_pg_t;

  // Folds per-bit propagate/generate of one group into the group pair, LSB first.
  function automatic grp_pg_t grp_pg(input logic [GROUP_W-1:0] p,
                                     input logic [GROUP_W-1:0] g);
    grp_pg_t r;
    r.g = 1'b0;
    r.p = 1'b1;
    for (int i = 0; i < GROUP_W; i++) begin
      r.g = g[i] | (p[i] & r.g);
      r.p = r.p & p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] nr1;
  logic [WIDTH-1:0] nr2;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf;
  logic             G;
  logic             P;

  // Traffic source/sink side.
  modport master (
    output in_valid, nr1, nr2, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, ovf, G, P
  );

  // Adder side.
  modport slave (
    input  in_valid, nr1, nr2, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, ovf, G, P
  );
endinterface

// File: rtl/cla_group.sv
// One GROUP_W-bit adder slice: ripple sum inside the group, group generate/propagate out.
// Latency: combinational.
// Backpressure: none.
module cla_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               grp_g,
  output logic               grp_p
);

  logic    ripple;
  grp_pg_t pg;

  // Ripple the carry through the slice and derive the group pair.
  always_comb begin
    ripple = cin;
    sum    = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ ripple;
      ripple = (a[i] & b[i]) | ((a[i] | b[i]) & ripple);
    end
    pg = grp_pg(a | b, a & b);
  end

  assign grp_g = pg.g;
  assign grp_p = pg.p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead add/subtract; optional signed saturation (CLA_PIPE_SAT_EN).
// Latency: 2 cycles from operand transfer to out_valid, 1 beat/cycle throughput.
// Backpressure: out_ready gates both stages; in_ready falls combinationally when the pipe is full.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  cla_pipe_adder_if.slave bus
);

  localparam int NG = WIDTH / GROUP_W;

  // Stage 1 state: per-bit p/g, operands (B already inverted for subtract), carry-in, group pairs.
  logic                s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    p_q, p_d;
  logic [WIDTH-1:0]    g_q, g_d;
  logic                cin_q, cin_d;
  grp_pg_t [NG-1:0]    grp_q, grp_d;

  // Stage 2 state: final result beat.
  logic                s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic                wg_q, wg_d;
  logic                wp_q, wp_d;

  // Front-end and stage-2 combinational values.
  mode_e               mode;
  logic [WIDTH-1:0]    b_eff;
  logic                cin_eff;
  logic [WIDTH-1:0]    p_in;
  logic [WIDTH-1:0]    g_in;
  grp_pg_t [NG-1:0]    grp_in;
  logic [NG:0]         c;
  logic [WIDTH-1:0]    sum_raw;
  logic [NG-1:0]       ig;
  logic [NG-1:0]       ip;
  logic                ovf_raw;
  logic [WIDTH-1:0]    sum_fin;
  logic                word_g;
  logic                word_p;

  // Handshake: a stage may load when it is empty or the stage after it is moving.
  logic s2_load;
  logic s1_mv;
  logic in_take;

  assign s2_load      = !s2_vld_q || bus.out_ready;
  assign s1_mv        = s1_vld_q && s2_load;
  assign bus.in_ready = !rst && (!s1_vld_q || s2_load);
  assign in_take      = bus.in_valid && bus.in_ready;

  assign mode = mode_e'(bus.sub);

  // Condition operands for the selected mode and form per-bit and group p/g.
  always_comb begin
    b_eff   = (mode == MODE_SUB) ? ~bus.nr2 : bus.nr2;
    cin_eff = (mode == MODE_SUB) ? 1'b1 : bus.carry_in;
    p_in    = bus.nr1 | b_eff;
    g_in    = bus.nr1 & b_eff;
    grp_in  = '0;
    for (int k = 0; k < NG; k++) begin
      grp_in[k] = grp_pg(p_in[k*GROUP_W +: GROUP_W], g_in[k*GROUP_W +: GROUP_W]);
    end
  end

  // Stage 1 next state: load on input transfer, empty when its beat moves on.
  always_comb begin
    s1_vld_d = s1_vld_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    g_d      = g_q;
    cin_d    = cin_q;
    grp_d    = grp_q;
    if (in_take) begin
      s1_vld_d = 1'b1;
      a_d      = bus.nr1;
      b_d      = b_eff;
      p_d      = p_in;
      g_d      = g_in;
      cin_d    = cin_eff;
      grp_d    = grp_in;
    end else if (s1_mv) begin
      s1_vld_d = 1'b0;
    end
  end

  // Lookahead across groups from the registered group pairs.
  always_comb begin
    c    = '0;
    c[0] = cin_q;
    for (int k = 0; k < NG; k++) begin
      c[k+1] = grp_q[k].g | (grp_q[k].p & c[k]);
    end
  end

  // Slices add p and g: (a|b)+(a&b) == a+b, so the registered p/g feed the adders directly.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group u_grp (
      .a     (p_q[k*GROUP_W +: GROUP_W]),
      .b     (g_q[k*GROUP_W +: GROUP_W]),
      .cin   (c[k]),
      .sum   (sum_raw[k*GROUP_W +: GROUP_W]),
      .grp_g (ig[k]),
      .grp_p (ip[k])
    );
  end

  // Word-level G/P, signed overflow and optional saturation of the stage-2 result.
  always_comb begin
    word_g = 1'b0;
    word_p = 1'b1;
    for (int k = 0; k < NG; k++) begin
      word_g = ig[k] | (ip[k] & word_g);
      word_p = word_p & ip[k];
    end
    ovf_raw = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_raw[WIDTH-1] != a_q[WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
    if (ovf_raw) begin
      sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_fin = sum_raw;
    end
`else
    sum_fin = sum_raw;
`endif
  end

  // Stage 2 next state: capture stage 1 when it moves, empty on output transfer.
  always_comb begin
    s2_vld_d = s2_vld_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    wg_d     = wg_q;
    wp_d     = wp_q;
    if (s1_mv) begin
      s2_vld_d = 1'b1;
      sum_d    = sum_fin;
      cout_d   = c[NG];
      ovf_d    = ovf_raw;
      wg_d     = word_g;
      wp_d     = word_p;
    end else if (s2_vld_q && bus.out_ready) begin
      s2_vld_d = 1'b0;
    end
  end

  // Pipeline registers; reset drops every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      g_q      <= '0;
      cin_q    <= 1'b0;
      grp_q    <= '0;
      s2_vld_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wg_q     <= 1'b0;
      wp_q     <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      g_q      <= g_d;
      cin_q    <= cin_d;
      grp_q    <= grp_d;
      s2_vld_q <= s2_vld_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      wg_q     <= wg_d;
      wp_q     <= wp_d;
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.G         = wg_q;
  assign bus.P         = wp_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomized and directed bench for cla_pipe_adder against an arithmetic reference model.
// Latency: checks the 2-cycle operand-to-result delay on isolated beats.
// Backpressure: exercises out_ready stalls, full-pipe stalls and reset with beats in flight.
module tb_cla_pipe_adder;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic         g;
    logic         p;
  } exp_t;

  logic clk;
  logic rst;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_in  = 0;
  int   n_out = 0;
  int   n_drop = 0;
  int   stall_cnt = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic s);
    exp_t e;
    int ua, ub, sa, sb, full, sres, beff;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      full = ua - ub;
      e.co = (ua >= ub);
      sres = sa - sb;
      beff = 65535 - ub;
    end else begin
      full = ua + ub + int'(cin);
      e.co = (full > 65535);
      sres = sa + sb + int'(cin);
      beff = ub;
    end
    e.sum = full[W-1:0];
    e.ovf = (sres > 32767) || (sres < -32768);
`ifdef CLA_PIPE_SAT_EN
    if (e.ovf) e.sum = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.g = (ua + beff) > 65535;
    e.p = ((ua | beff) & 65535) == 65535;
    return e;
  endfunction

  // Scoreboard: inputs accepted and results taken are both decided at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.nr1, bus.nr2, bus.carry_in, bus.sub));
        n_in++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", bus.sum, e.sum);
          chk("carry_out", bus.carry_out, e.co);
          chk("ovf", bus.ovf, e.ovf);
          chk("G", bus.G, e.g);
          chk("P", bus.P, e.p);
          n_out++;
        end
      end
    end
  end

  // Offer one beat starting just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic s);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.nr1      = a;
    bus.nr2      = b;
    bus.carry_in = cin;
    bus.sub      = s;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Isolated beat into an empty pipe; checks latency and captures the result.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic s, output exp_t r);
    send(a, b, cin, s);
    @(negedge clk);
    chk("latency_early", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1'b1);
    r.sum = bus.sum;
    r.co  = bus.carry_out;
    r.ovf = bus.ovf;
    r.g   = bus.G;
    r.p   = bus.P;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] corner [4];
    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h7FFF;
    corner[3] = 16'h8000;
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  logic rnd_done;

  initial begin
    exp_t r;
    int   outs_before;
    int   guard;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.nr1       = '0;
    bus.nr2       = '0;
    bus.carry_in  = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rnd_done      = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_flags", {bus.carry_out, bus.ovf, bus.G, bus.P}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed values.
    run_one(16'h1234, 16'h4321, 1'b0, 1'b0, r);
    chk("d_add_sum", r.sum, 16'h5555);
    chk("d_add_co_ovf", {r.co, r.ovf}, 2'b00);

    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, r);
    chk("d_wrap_sum", r.sum, 16'h0000);
    chk("d_wrap_co_ovf", {r.co, r.ovf}, 2'b10);
    chk("d_wrap_PG", {r.p, r.g}, 2'b11);

    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, r);
    chk("d_povf_ovf", r.ovf, 1'b1);
`ifdef CLA_PIPE_SAT_EN
    chk("d_povf_sum", r.sum, 16'h7FFF);
`else
    chk("d_povf_sum", r.sum, 16'h8000);
`endif

    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, r);
    chk("d_sub_sum", r.sum, 16'hFFFE);
    chk("d_sub_co_ovf", {r.co, r.ovf}, 2'b00);

    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, r);
    chk("d_sub_ovf", r.ovf, 1'b1);

    run_one(16'hA5C3, 16'h0000, 1'b1, 1'b1, r);
    chk("d_sub0_sum", r.sum, 16'hA5C3);
    chk("d_sub0_co_ovf", {r.co, r.ovf}, 2'b10);

    run_one(16'h00FF, 16'h0000, 1'b1, 1'b0, r);
    chk("d_cin_sum", r.sum, 16'h0100);

    // Stream of 8 with out_ready low for three cycles.
    stall_cnt   = 0;
    outs_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("bp_stall_seen", (stall_cnt > 0), 1'b1);
    chk("bp_beats_out", n_out - outs_before, 32'd8);

    // Reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_out_valid", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    n_drop = n_drop + exp_q.size();
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    guard = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) guard++;
    end
    chk("stale_after_rst", guard, 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic under random backpressure.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 1) * $urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        int g;
        g = 0;
        while (!rnd_done && g < 5000) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          g++;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("beats_conserved", n_out, n_in - n_drop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16; operand/sum width; SHALL be a multiple of 4, at least 8.
REQ-002 Parameter GROUP_W, default 4; lookahead group size; SHALL be a localparam taken from the package, not overridable.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 nr1  input  WIDTH  operand A.
REQ-008 nr2  input  WIDTH  operand B.
REQ-009 carry_in  input  1  carry into bit 0, add mode only.
REQ-010 sub  input  1  0 = A+B+carry_in; 1 = A-B (A + ~B + 1, carry_in ignored).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 carry_out  output  1  carry from MSB (subtract: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow: operands (B inverted in sub) same sign, sum sign differs.
REQ-016 G, P  output  1 each  whole-word generate/propagate of the accepted operands, for cascading.

Function
REQ-017 Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
REQ-018 Two-register pipeline: S1 holds per-bit p=a|b, g=a&b, operands, effective carry-in, group P/G; S2 holds sum, carry_out, ovf, G, P.
REQ-019 Latency exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-020 Group carries SHALL use lookahead: c[k+1] = G[k] | P[k]&c[k] over WIDTH/4 groups; ripple only inside a group.
REQ-021 Each stage advances when it is empty or the next stage advances; in_ready = !S1_valid | S1_advance; combinational out_ready→in_ready path permitted.
REQ-022 Under out_ready=0 with both stages full, in_ready=0 and no register changes; no beat lost or duplicated.
REQ-023 Simultaneous input and output transfer with pipe full SHALL keep the pipe full and shift by one.
REQ-024 Wrap-around: sum is modulo 2^WIDTH; carry_out/ovf report the excess.
REQ-025 sub=1 with nr2=0 SHALL yield sum=nr1, carry_out=1, ovf=0.

Reset
REQ-026 rst=1 SHALL clear S1/S2 valid immediately: out_valid=0, sum=0, carry_out=0, ovf=0, G=0, P=0.
REQ-027 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-028 Reset mid-operation discards all in-flight beats; no result for them ever appears.

Configuration
REQ-029 Macro CLA_PIPE_SAT_EN: when defined, signed saturation applied in S2: positive overflow → sum=0111..1, negative → 1000..0; ovf still reports the event; carry_out unchanged.
REQ-030 Without CLA_PIPE_SAT_EN, sum wraps per REQ-024; no saturation logic instantiated.

Structure
REQ-031 Package cla_pkg SHALL hold GROUP_W=4, the mode encoding (MODE_ADD=0, MODE_SUB=1) and a group P/G struct type.
REQ-032 One sub-module cla_group: combinational GROUP_W-bit slice (inputs a, b, cin; outputs sum, group G, group P), instantiated WIDTH/4 times.

Verification (WIDTH=16)
REQ-033 add 0x1234+0x4321, carry_in=0 -> two cycles later sum=0x5555, carry_out=0, ovf=0.
REQ-034 add 0xFFFF+0x0001, carry_in=0 -> sum=0x0000, carry_out=1, P=1, G=1; with SAT_EN also sum=0x0000, ovf=0.
REQ-035 add 0x7FFF+0x0001 -> ovf=1; sum=0x8000 without macro, 0x7FFF with CLA_PIPE_SAT_EN.
REQ-036 sub 0x0005-0x0007 -> sum=0xFFFE, carry_out=0, ovf=0; sub 0x8000-0x0001 -> ovf=1.
REQ-037 stream 8 beats, out_ready low cycles 3-5 -> in_ready low after pipe fills, results in order, none lost.
REQ-038 assert rst with 2 beats in flight -> out_valid=0 at once; no stale result after release.
